// File: rtl/tlx_resp_collector.sv
// TLX->AFU response collector: credit-managed response FIFO, per-afutag outstanding
// table that merges dl-split partial responses into a single completion per command.
module tlx_resp_collector #(
   parameter int unsigned TAGW         = 5,
   parameter int unsigned RESP_CREDITS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cmd_issue_valid,
   input  logic [15:0] cmd_issue_afutag,
   input  logic [1:0]  cmd_issue_dl,
   input  logic        tlx_afu_resp_valid,
   input  logic [7:0]  tlx_afu_resp_opcode,
   input  logic [15:0] tlx_afu_resp_afutag,
   input  logic [1:0]  tlx_afu_resp_dl,
   input  logic [3:0]  tlx_afu_resp_code,
   output logic [3:0]  afu_tlx_resp_initial_credit,
   output logic        afu_tlx_resp_credit,
   output logic        afu_tlx_resp_rd_req,
   output logic [2:0]  afu_tlx_resp_rd_cnt,
   output logic        cpl_valid,
   input  logic        cpl_ready,
   output logic [15:0] cpl_afutag,
   output logic        cpl_is_write,
   output logic [1:0]  cpl_status,
   output logic [3:0]  cpl_code,
   output logic [2:0]  err_sticky
);

   localparam int unsigned NTAGS = 1 << TAGW;
   localparam int unsigned AW    = (RESP_CREDITS > 1) ? $clog2(RESP_CREDITS) : 1;

   localparam logic [7:0] OP_RD_RESP = 8'h04;
   localparam logic [7:0] OP_RD_FAIL = 8'h05;
   localparam logic [7:0] OP_WR_RESP = 8'h08;
   localparam logic [7:0] OP_WR_FAIL = 8'h09;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_FAILED  = 2'd1;
   localparam logic [1:0] ST_UNKNOWN = 2'd2;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [15:0] afutag;
      logic [1:0]  dl;
      logic [3:0]  code;
   } beat_t;

   function automatic logic [2:0] beats(input logic [1:0] dl);
      case (dl)
         2'b10:   beats = 3'd2;
         2'b11:   beats = 3'd4;
         default: beats = 3'd1;
      endcase
   endfunction

   beat_t          fifo_mem [2**AW];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [3:0]     count;

   logic           tbl_valid [NTAGS];
   logic [2:0]     tbl_exp   [NTAGS];
   logic [2:0]     tbl_rcv   [NTAGS];
   logic           tbl_fail  [NTAGS];
   logic [3:0]     tbl_code  [NTAGS];

   logic           full, push, pop;
   beat_t          head;
   logic [TAGW-1:0] head_idx, issue_idx;
   logic           known_op, is_fail, is_write, hit, done, cpl_fire;
   logic [2:0]     new_rcv;
   logic           new_fail;
   logic [3:0]     new_code;

   assign afu_tlx_resp_initial_credit = 4'(RESP_CREDITS);

   always_comb begin
      full      = (count == 4'(RESP_CREDITS));
      push      = tlx_afu_resp_valid && !full;
      pop       = (count != '0) && (!cpl_valid || cpl_ready);
      head      = fifo_mem[rd_ptr];
      head_idx  = head.afutag[TAGW-1:0];
      issue_idx = cmd_issue_afutag[TAGW-1:0];
      known_op  = (head.opcode == OP_RD_RESP) || (head.opcode == OP_RD_FAIL) ||
                  (head.opcode == OP_WR_RESP) || (head.opcode == OP_WR_FAIL);
      is_fail   = (head.opcode == OP_RD_FAIL) || (head.opcode == OP_WR_FAIL);
      is_write  = (head.opcode == OP_WR_RESP) || (head.opcode == OP_WR_FAIL);
      hit       = tbl_valid[head_idx];
      new_rcv   = tbl_rcv[head_idx] + beats(head.dl);
      new_fail  = tbl_fail[head_idx] | is_fail;
      // only the first failure code for a tag is kept
      new_code  = tbl_fail[head_idx] ? tbl_code[head_idx] : (is_fail ? head.code : '0);
      done      = hit && (new_rcv >= tbl_exp[head_idx]);
      cpl_fire  = pop && known_op && (!hit || done);
   end

   // FIFO storage carries no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= beat_t'{tlx_afu_resp_opcode, tlx_afu_resp_afutag,
                                            tlx_afu_resp_dl, tlx_afu_resp_code};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == AW'(RESP_CREDITS - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == AW'(RESP_CREDITS - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + {3'b000, push} - {3'b000, pop};
      end
   end

   // pop update first, issue afterwards so a same-cycle issue wins
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NTAGS; i++) begin
            tbl_valid[i] <= 1'b0;
            tbl_exp[i]   <= '0;
            tbl_rcv[i]   <= '0;
            tbl_fail[i]  <= 1'b0;
            tbl_code[i]  <= '0;
         end
      end else begin
         if (pop && known_op && hit) begin
            if (done) tbl_valid[head_idx] <= 1'b0;
            tbl_rcv[head_idx]  <= new_rcv;
            tbl_fail[head_idx] <= new_fail;
            tbl_code[head_idx] <= new_code;
         end
         if (cmd_issue_valid) begin
            tbl_valid[issue_idx] <= 1'b1;
            tbl_exp[issue_idx]   <= beats(cmd_issue_dl);
            tbl_rcv[issue_idx]   <= '0;
            tbl_fail[issue_idx]  <= 1'b0;
            tbl_code[issue_idx]  <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         afu_tlx_resp_credit <= 1'b0;
         afu_tlx_resp_rd_req <= 1'b0;
         afu_tlx_resp_rd_cnt <= '0;
         cpl_valid           <= 1'b0;
         cpl_afutag          <= '0;
         cpl_is_write        <= 1'b0;
         cpl_status          <= '0;
         cpl_code            <= '0;
         err_sticky          <= '0;
      end else begin
         afu_tlx_resp_credit <= pop;
         afu_tlx_resp_rd_req <= pop && (head.opcode == OP_RD_RESP);
         afu_tlx_resp_rd_cnt <= (pop && (head.opcode == OP_RD_RESP)) ? {1'b0, head.dl} : '0;

         if (cpl_fire) begin
            cpl_valid    <= 1'b1;
            cpl_afutag   <= head.afutag;
            cpl_is_write <= is_write;
            cpl_status   <= !hit ? ST_UNKNOWN : (new_fail ? ST_FAILED : ST_OK);
            cpl_code     <= hit ? new_code : '0;
         end else if (cpl_ready) begin
            cpl_valid <= 1'b0;
         end

         if (tlx_afu_resp_valid && full) err_sticky[0] <= 1'b1;
         if (cmd_issue_valid && (tbl_valid[issue_idx] || cmd_issue_dl == 2'b00))
            err_sticky[1] <= 1'b1;
         if (pop && (!known_op || head.dl == 2'b00)) err_sticky[2] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tlx_resp_collector.sv
// Directed bench for tlx_resp_collector: expected completions and read requests are
// queued at stimulus time and checked by an independent output monitor.
module tb_tlx_resp_collector;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cmd_issue_valid;
   logic [15:0] cmd_issue_afutag;
   logic [1:0]  cmd_issue_dl;
   logic        tlx_afu_resp_valid;
   logic [7:0]  tlx_afu_resp_opcode;
   logic [15:0] tlx_afu_resp_afutag;
   logic [1:0]  tlx_afu_resp_dl;
   logic [3:0]  tlx_afu_resp_code;
   logic [3:0]  afu_tlx_resp_initial_credit;
   logic        afu_tlx_resp_credit;
   logic        afu_tlx_resp_rd_req;
   logic [2:0]  afu_tlx_resp_rd_cnt;
   logic        cpl_valid;
   logic        cpl_ready;
   logic [15:0] cpl_afutag;
   logic        cpl_is_write;
   logic [1:0]  cpl_status;
   logic [3:0]  cpl_code;
   logic [2:0]  err_sticky;

   typedef struct packed {
      logic [15:0] tag;
      logic        wr;
      logic [1:0]  st;
      logic [3:0]  code;
   } cpl_t;

   cpl_t       exp_cpl_q [$];
   logic [2:0] exp_rd_q  [$];
   int         tests = 0;
   int         fails = 0;
   int         credit_cnt = 0;

   always #5 clk = ~clk;

   tlx_resp_collector #(.TAGW(5), .RESP_CREDITS(4)) dut (
      .clk                         (clk),
      .resetn                      (resetn),
      .cmd_issue_valid             (cmd_issue_valid),
      .cmd_issue_afutag            (cmd_issue_afutag),
      .cmd_issue_dl                (cmd_issue_dl),
      .tlx_afu_resp_valid          (tlx_afu_resp_valid),
      .tlx_afu_resp_opcode         (tlx_afu_resp_opcode),
      .tlx_afu_resp_afutag         (tlx_afu_resp_afutag),
      .tlx_afu_resp_dl             (tlx_afu_resp_dl),
      .tlx_afu_resp_code           (tlx_afu_resp_code),
      .afu_tlx_resp_initial_credit (afu_tlx_resp_initial_credit),
      .afu_tlx_resp_credit         (afu_tlx_resp_credit),
      .afu_tlx_resp_rd_req         (afu_tlx_resp_rd_req),
      .afu_tlx_resp_rd_cnt         (afu_tlx_resp_rd_cnt),
      .cpl_valid                   (cpl_valid),
      .cpl_ready                   (cpl_ready),
      .cpl_afutag                  (cpl_afutag),
      .cpl_is_write                (cpl_is_write),
      .cpl_status                  (cpl_status),
      .cpl_code                    (cpl_code),
      .err_sticky                  (err_sticky)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: samples on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (afu_tlx_resp_credit) credit_cnt++;
         if (afu_tlx_resp_rd_req) begin
            if (exp_rd_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rd_req_unexpected: got cnt %0d expected no request", afu_tlx_resp_rd_cnt);
            end else begin
               check("rd_cnt", 32'(afu_tlx_resp_rd_cnt), 32'(exp_rd_q.pop_front()));
            end
         end
         if (cpl_valid && cpl_ready) begin
            if (exp_cpl_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL cpl_unexpected: got tag 0x%0h status %0d expected none",
                        cpl_afutag, cpl_status);
            end else begin
               check("cpl {tag,wr,st,code}",
                     32'({cpl_afutag, cpl_is_write, cpl_status, cpl_code}),
                     32'(exp_cpl_q.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic issue(input logic [15:0] tag, input logic [1:0] dl);
      cmd_issue_valid  = 1'b1;
      cmd_issue_afutag = tag;
      cmd_issue_dl     = dl;
      tick();
      cmd_issue_valid  = 1'b0;
   endtask

   task automatic resp(input logic [7:0] op, input logic [15:0] tag,
                       input logic [1:0] dl, input logic [3:0] code);
      tlx_afu_resp_valid  = 1'b1;
      tlx_afu_resp_opcode = op;
      tlx_afu_resp_afutag = tag;
      tlx_afu_resp_dl     = dl;
      tlx_afu_resp_code   = code;
      tick();
      tlx_afu_resp_valid  = 1'b0;
   endtask

   initial begin
      resetn              = 1'b0;
      cmd_issue_valid     = 1'b0;
      cmd_issue_afutag    = '0;
      cmd_issue_dl        = '0;
      tlx_afu_resp_valid  = 1'b0;
      tlx_afu_resp_opcode = '0;
      tlx_afu_resp_afutag = '0;
      tlx_afu_resp_dl     = '0;
      tlx_afu_resp_code   = '0;
      cpl_ready           = 1'b1;
      idle(3);
      check("rst_cpl_valid", 32'(cpl_valid), 0);
      check("rst_credit", 32'(afu_tlx_resp_credit), 0);
      check("rst_rd_req", 32'(afu_tlx_resp_rd_req), 0);
      check("rst_err", 32'(err_sticky), 0);
      check("rst_init_credit", 32'(afu_tlx_resp_initial_credit), 4);
      resetn = 1'b1;
      idle(2);

      // 1: 256B read split into two 128B responses
      credit_cnt = 0;
      issue(16'd3, 2'b11);
      exp_rd_q.push_back(3'd2);
      resp(8'h04, 16'd3, 2'b10, 4'h0);
      idle(3);
      check("t1_no_cpl_after_first", 32'(exp_cpl_q.size() + int'(cpl_valid)), 0);
      exp_rd_q.push_back(3'd2);
      exp_cpl_q.push_back(cpl_t'{16'd3, 1'b0, 2'd0, 4'h0});
      resp(8'h04, 16'd3, 2'b10, 4'h0);
      idle(4);
      check("t1_credits", 32'(credit_cnt), 2);
      check("t1_cpl_drained", 32'(exp_cpl_q.size()), 0);

      // 2: write with failed then good partial response
      credit_cnt = 0;
      issue(16'd5, 2'b10);
      exp_cpl_q.push_back(cpl_t'{16'd5, 1'b1, 2'd1, 4'hE});
      resp(8'h09, 16'd5, 2'b01, 4'hE);
      resp(8'h08, 16'd5, 2'b01, 4'h0);
      idle(4);
      check("t2_credits", 32'(credit_cnt), 2);
      check("t2_cpl_drained", 32'(exp_cpl_q.size()), 0);

      // 3: unknown tag, with N+2 latency check
      credit_cnt = 0;
      exp_rd_q.push_back(3'd1);
      exp_cpl_q.push_back(cpl_t'{16'd9, 1'b0, 2'd2, 4'h0});
      resp(8'h04, 16'd9, 2'b01, 4'h0);
      tick();
      check("t3_latency_cpl_valid", 32'(cpl_valid), 1);
      check("t3_latency_credit", 32'(afu_tlx_resp_credit), 1);
      idle(3);
      check("t3_credits", 32'(credit_cnt), 1);
      issue(16'd9, 2'b01);
      exp_cpl_q.push_back(cpl_t'{16'd9, 1'b1, 2'd0, 4'h0});
      resp(8'h08, 16'd9, 2'b01, 4'h0);
      idle(4);
      check("t3_table_unchanged_err", 32'(err_sticky), 0);
      check("t3_cpl_drained", 32'(exp_cpl_q.size()), 0);

      // 4: completion held, five beats into a four-entry FIFO
      cpl_ready = 1'b0;
      exp_rd_q.push_back(3'd1);
      exp_cpl_q.push_back(cpl_t'{16'd20, 1'b0, 2'd2, 4'h0});
      resp(8'h04, 16'd20, 2'b01, 4'h0);
      idle(2);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_cpl_q.push_back(cpl_t'{16'(21 + i), 1'b1, 2'd2, 4'h0});
         resp(8'h08, 16'(21 + i), 2'b01, 4'h0);
      end
      idle(2);
      check("t4_overflow_err", 32'(err_sticky[0]), 1);
      check("t4_held_valid", 32'(cpl_valid), 1);
      check("t4_held_tag", 32'(cpl_afutag), 20);
      credit_cnt = 0;
      cpl_ready = 1'b1;
      idle(10);
      check("t4_credits", 32'(credit_cnt), 4);
      check("t4_cpl_drained", 32'(exp_cpl_q.size()), 0);

      // 5: duplicate issue and illegal opcode
      issue(16'd2, 2'b01);
      check("t5_first_issue_ok", 32'(err_sticky[1]), 0);
      issue(16'd2, 2'b01);
      tick();
      check("t5_dup_err", 32'(err_sticky[1]), 1);
      credit_cnt = 0;
      resp(8'h01, 16'd7, 2'b01, 4'h0);
      idle(4);
      check("t5_bad_op_credit", 32'(credit_cnt), 1);
      check("t5_bad_op_err", 32'(err_sticky[2]), 1);

      // 6: reset with beats queued behind a held completion
      cpl_ready = 1'b0;
      resp(8'h08, 16'd10, 2'b01, 4'h0);
      idle(2);
      for (int i = 0; i < 3; i++) resp(8'h08, 16'(11 + i), 2'b01, 4'h0);
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      exp_cpl_q.delete();
      exp_rd_q.delete();
      check("t6_cpl_valid", 32'(cpl_valid), 0);
      check("t6_err", 32'(err_sticky), 0);
      check("t6_credit", 32'(afu_tlx_resp_credit), 0);
      credit_cnt = 0;
      cpl_ready = 1'b1;
      idle(10);
      check("t6_no_stray_credit", 32'(credit_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
